hilo_div_ctrl: RTL and testbench

//  Sequences the 32-iteration radix-2 divider for DIV/DIVU and owns the architectural HI/LO registers.

---
 rtl/hilo_pkg.sv | 19 +
 rtl/hilo_div_ctrl.sv | 133 +++++++++++++
 tb/tb_hilo_div_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divide controller: op codes, FSM states
// and the value LO takes when a divide by zero bypasses the divider.
package hilo_pkg;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ARM   = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/hilo_div_ctrl.sv
// HI/LO owner and sequencer for the external 32-iteration radix-2 divider.
// Accepts one op at a time in IDLE, launches the divider for DIV/DIVU,
// stalls the control unit until the result lands, and guards the wait with a
// watchdog that raises a sticky err flag if the divider never reports done.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        op_ready,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WDOG_W-1:0] wdog;
  logic [31:0]       hi_nxt;
  logic [31:0]       lo_nxt;
  logic              load_ops;
  logic              set_err;

  // Next-state, handshake and HI/LO write selection for the divide sequence
  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    div_start = 1'b0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    load_ops  = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          case (op_code)
            OP_DIV, OP_DIVU: begin
              if (rt_val != 32'd0) begin
                load_ops  = 1'b1;
                state_nxt = ST_START;
              end else begin
                hi_nxt = rs_val;
                lo_nxt = DIV_ZERO_LO;
              end
            end
            OP_MTHI: hi_nxt = rs_val;
            OP_MTLO: lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      ST_START: begin
        div_start = 1'b1;
        state_nxt = ST_ARM;
      end
      ST_ARM: begin
        // The divider's busy bit is not meaningful until after it has loaded
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done) begin
          hi_nxt    = div_r;
          lo_nxt    = div_q;
          state_nxt = ST_IDLE;
        end else if (wdog == WDOG_LAST) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign stall = ~op_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Watchdog counts cycles spent waiting and restarts whenever WAIT is left
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wdog <= '0;
    else if (state == ST_WAIT) wdog <= wdog + 1'b1;
    else                      wdog <= '0;
  end

  // Architectural HI/LO registers and the sticky watchdog error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi  <= 32'd0;
      lo  <= 32'd0;
      err <= 1'b0;
    end else begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (set_err) err <= 1'b1;
    end
  end

  // Operand and signedness registers presented to the divider for the whole op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_signed   <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
    end else if (load_ops) begin
      div_signed   <= (op_code == OP_DIV);
      div_dividend <= rs_val;
      div_divisor  <= rt_val;
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: a behavioural divider environment,
// a cycle-level reference model of the controller's visible behaviour,
// directed cases with literal expectations, then randomized ops.
module tb_hilo_div_ctrl;
  import hilo_pkg::*;

  localparam int WDOG = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        op_ready, stall, err, div_start, div_signed, div_done;
  logic [31:0] hi, lo, div_dividend, div_divisor, div_q, div_r;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  hilo_div_ctrl #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .stall(stall),
    .hi(hi), .lo(lo), .err(err), .div_start(div_start),
    .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_q(div_q), .div_r(div_r),
    .div_done(div_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_q(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (sgn) return $signed(a) / $signed(b);
    return a / b;
  endfunction

  function automatic logic [31:0] ref_r(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (sgn) return $signed(a) % $signed(b);
    return a % b;
  endfunction

  // Divider environment: loads on start, busy for 32 cycles, no reset
  logic        stub = 1'b0;
  int          dcnt = 0;
  logic [31:0] dq = 32'd0;
  logic [31:0] dr = 32'd0;
  always @(posedge clk) begin
    if (div_start) begin
      dcnt <= 32;
      dq   <= ref_q(div_signed, div_dividend, div_divisor);
      dr   <= ref_r(div_signed, div_dividend, div_divisor);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done = stub ? 1'b0 : (dcnt == 0);
  assign div_q    = dq;
  assign div_r    = dr;

  // Reference model: an op occupies the controller for a fixed number of cycles
  logic [31:0] m_hi = 0, m_lo = 0, m_q = 0, m_r = 0, m_dvd = 0, m_dvs = 0;
  logic        m_err = 0, m_start = 0, m_signed = 0, m_abort = 0;
  int          m_busy = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= 0; m_lo <= 0; m_err <= 0; m_start <= 0; m_signed <= 0;
      m_dvd <= 0; m_dvs <= 0; m_busy <= 0; m_abort <= 0; m_q <= 0; m_r <= 0;
    end else begin
      m_start <= 1'b0;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          if (m_abort) m_err <= 1'b1;
          else begin
            m_hi <= m_r;
            m_lo <= m_q;
          end
        end
      end else if (op_valid) begin
        if (op_code == OP_MTHI) m_hi <= rs_val;
        else if (op_code == OP_MTLO) m_lo <= rs_val;
        else if (rt_val == 0) begin
          m_hi <= rs_val;
          m_lo <= 32'hFFFF_FFFF;
        end else begin
          m_busy   <= stub ? WDOG + 2 : 34;
          m_abort  <= stub;
          m_start  <= 1'b1;
          m_signed <= (op_code == OP_DIV);
          m_dvd    <= rs_val;
          m_dvs    <= rt_val;
          m_q      <= ref_q(op_code == OP_DIV, rs_val, rt_val);
          m_r      <= ref_r(op_code == OP_DIV, rs_val, rt_val);
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (div_start === 1'b1) starts++;
      check_val("op_ready", {31'd0, op_ready}, {31'd0, m_busy == 0});
      check_val("stall", {31'd0, stall}, {31'd0, m_busy != 0});
      check_val("hi", hi, m_hi);
      check_val("lo", lo, m_lo);
      check_val("err", {31'd0, err}, {31'd0, m_err});
      check_val("div_start", {31'd0, div_start}, {31'd0, m_start});
      check_val("div_signed", {31'd0, div_signed}, {31'd0, m_signed});
      check_val("div_dividend", div_dividend, m_dvd);
      check_val("div_divisor", div_divisor, m_dvs);
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one op while idle and wait for the stall to end; n = stall cycles
  task automatic apply_op(input logic [1:0] code, input logic [31:0] rs, input logic [31:0] rt, output int n);
    op_valid = 1'b1; op_code = code; rs_val = rs; rt_val = rt;
    @(posedge clk); #1;
    op_valid = 1'b0;
    n = 0;
    while (stall && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    if (stall) begin
      checks++; errors++;
      $display("[TB] FAIL op_timeout: stall still %b after %0d cycles, required 0", stall, n);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation time %0t exceeded, required completion", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n, s0, k, cyc;
    logic [1:0]  code;
    logic [31:0] rs, rt;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_val("reset_hi", hi, 32'd0);
    check_val("reset_lo", lo, 32'd0);
    check_val("reset_err", {31'd0, err}, 32'd0);
    check_val("reset_ready", {31'd0, op_ready}, 32'd1);

    apply_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    check_val("div_neg_stall", n, 34);
    check_val("div_neg_lo", lo, 32'hFFFF_FFFD);
    check_val("div_neg_hi", hi, 32'hFFFF_FFFF);

    s0 = starts;
    apply_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, n);
    check_val("divu_lo", lo, 32'h0FFF_FFFF);
    check_val("divu_hi", hi, 32'hF);
    check_val("divu_signed", {31'd0, div_signed}, 32'd0);
    check_val("divu_starts", starts - s0, 1);

    s0 = starts;
    apply_op(OP_DIV, 32'd5, 32'd0, n);
    check_val("div0_stall", n, 0);
    check_val("div0_hi", hi, 32'd5);
    check_val("div0_lo", lo, 32'hFFFF_FFFF);
    check_val("div0_ready", {31'd0, op_ready}, 32'd1);
    @(negedge clk); #1;
    check_val("div0_starts", starts - s0, 0);

    op_valid = 1'b1; op_code = OP_DIV; rs_val = 32'd1000; rt_val = 32'd3;
    @(posedge clk); #1;
    op_code = OP_MTHI; rs_val = 32'hCAFE; rt_val = 32'd9;
    k = 0;
    while (!op_ready && k < 300) begin
      k++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    check_val("held_wait", k, 34);
    check_val("held_hi", hi, 32'hCAFE);
    check_val("held_lo", lo, 32'd333);

    op_valid = 1'b1; op_code = OP_DIV; rs_val = 32'h1234_5678; rt_val = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("rst_mid_hi", hi, 32'd0);
    check_val("rst_mid_lo", lo, 32'd0);
    check_val("rst_mid_ready", {31'd0, op_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    apply_op(OP_DIV, 32'd100, 32'd7, n);
    check_val("after_rst_lo", lo, 32'd14);
    check_val("after_rst_hi", hi, 32'd2);

    stub = 1'b1;
    apply_op(OP_DIVU, 32'd50, 32'd5, n);
    stub = 1'b0;
    check_val("wdog_stall", n, WDOG + 2);
    check_val("wdog_err", {31'd0, err}, 32'd1);
    check_val("wdog_hi", hi, 32'd2);
    check_val("wdog_lo", lo, 32'd14);
    pulse_reset();
    check_val("err_cleared", {31'd0, err}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      code = 2'($urandom_range(0, 3));
      rs = $urandom_range(0, 3) == 0 ? 32'(-$urandom_range(1, 50)) : $urandom;
      case ($urandom_range(0, 3))
        0:       rt = 32'd0;
        1:       rt = $urandom_range(1, 20);
        2:       rt = 32'(-$urandom_range(1, 9));
        default: rt = $urandom;
      endcase
      if (code == OP_DIV && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
      if ((code == OP_DIV || code == OP_DIVU) && rt != 0 && $urandom_range(0, 7) == 0) begin
        op_valid = 1'b1; op_code = code; rs_val = rs; rt_val = rt;
        @(posedge clk); #1;
        op_valid = 1'b0;
        cyc = $urandom_range(0, 40);
        repeat (cyc) @(posedge clk);
        #1 pulse_reset();
      end else begin
        apply_op(code, rs, rt, n);
      end
      cyc = $urandom_range(0, 3);
      repeat (cyc) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
